// File: rtl/l2_mac_table_aging.sv
// MAC address table with source learning, destination lookup, per-entry aging
// and least-age replacement when full. Whole table is held in flops for parallel match.
module l2_mac_table_aging #(
    parameter int ADDR_WIDTH      = 4,
    parameter int NUM_PORTS       = 4,
    parameter int TABLE_SIZE      = 16,
    parameter int AGE_WIDTH       = 3,
    parameter int AGE_TICK_CYCLES = 1024,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int IW = $clog2(TABLE_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  learn_valid,
    input  logic [ADDR_WIDTH-1:0] learn_mac,
    input  logic [PW-1:0]         learn_port,
    input  logic                  lookup_valid,
    input  logic [ADDR_WIDTH-1:0] lookup_mac,
    output logic                  result_valid,
    output logic                  result_hit,
    output logic [PW-1:0]         result_port,
    output logic                  result_flood,
    output logic [IW:0]           entry_count,
    output logic                  station_move
);

    localparam int PSW = $clog2(AGE_TICK_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] BCAST   = '1;
    localparam logic [AGE_WIDTH-1:0]  AGE_MAX = '1;
    localparam logic [PSW-1:0]        TICK_AT = PSW'(AGE_TICK_CYCLES - 1);

    logic [TABLE_SIZE-1:0] valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] mac_q  [TABLE_SIZE];
    logic [ADDR_WIDTH-1:0] mac_d  [TABLE_SIZE];
    logic [PW-1:0]         port_q [TABLE_SIZE];
    logic [PW-1:0]         port_d [TABLE_SIZE];
    logic [AGE_WIDTH-1:0]  age_q  [TABLE_SIZE];
    logic [AGE_WIDTH-1:0]  age_d  [TABLE_SIZE];

    logic [PSW-1:0] presc_q, presc_d;
    logic           result_valid_q, result_valid_d;
    logic           result_hit_q, result_hit_d;
    logic [PW-1:0]  result_port_q, result_port_d;
    logic           result_flood_q, result_flood_d;
    logic [IW:0]    entry_count_q, entry_count_d;
    logic           station_move_q, station_move_d;

    logic [TABLE_SIZE-1:0] learn_match;
    logic [TABLE_SIZE-1:0] lookup_match;
    logic [TABLE_SIZE-1:0] write_en;
    logic                  tick;
    logic                  learn_en;
    logic                  learn_any;
    logic                  lookup_hit;
    logic                  free_found;
    logic [IW-1:0]         free_idx;
    logic [IW-1:0]         min_idx;
    logic [IW-1:0]         target_idx;
    logic [AGE_WIDTH-1:0]  min_age;
    logic [PW-1:0]         learn_old_port;
    logic [PW-1:0]         lookup_port;

    assign tick     = (presc_q == TICK_AT);
    assign learn_en = learn_valid && !flush && (learn_mac != BCAST);

    generate
        for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_match
            assign learn_match[gi]  = valid_q[gi] && (mac_q[gi] == learn_mac);
            assign lookup_match[gi] = valid_q[gi] && (mac_q[gi] == lookup_mac);
        end
    endgenerate

    // A MAC occupies at most one entry, so OR-ing the matched ports selects it.
    always_comb begin
        free_found     = 1'b0;
        free_idx       = '0;
        min_age        = age_q[0];
        min_idx        = '0;
        learn_old_port = '0;
        lookup_port    = '0;
        for (int i = 0; i < TABLE_SIZE; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (age_q[i] < min_age) begin
                min_age = age_q[i];
                min_idx = IW'(i);
            end
            if (learn_match[i]) learn_old_port = learn_old_port | port_q[i];
            if (lookup_match[i]) lookup_port = lookup_port | port_q[i];
        end
    end

    assign learn_any  = |learn_match;
    assign lookup_hit = (lookup_mac != BCAST) && (|lookup_match);
    assign target_idx = free_found ? free_idx : min_idx;

    generate
        for (genvar gi = 0; gi < TABLE_SIZE; gi++) begin : g_wsel
            assign write_en[gi] = learn_en &&
                (learn_any ? learn_match[gi] : (target_idx == IW'(gi)));
        end
    endgenerate

    // A write wins over the aging tick for the entry it touches.
    always_comb begin
        valid_d       = valid_q;
        entry_count_d = '0;
        for (int i = 0; i < TABLE_SIZE; i++) begin
            mac_d[i]  = mac_q[i];
            port_d[i] = port_q[i];
            age_d[i]  = age_q[i];
            if (flush) begin
                valid_d[i] = 1'b0;
            end else if (write_en[i]) begin
                valid_d[i] = 1'b1;
                mac_d[i]   = learn_mac;
                port_d[i]  = learn_port;
                age_d[i]   = AGE_MAX;
            end else if (tick && valid_q[i]) begin
                if (age_q[i] == '0) valid_d[i] = 1'b0;
                else                age_d[i]   = age_q[i] - 1'b1;
            end
            entry_count_d = entry_count_d + (IW+1)'(valid_d[i]);
        end
    end

    always_comb begin
        presc_d        = (flush || tick) ? '0 : presc_q + 1'b1;
        station_move_d = learn_en && learn_any && (learn_old_port != learn_port);
        result_valid_d = lookup_valid;
        result_hit_d   = result_hit_q;
        result_port_d  = result_port_q;
        result_flood_d = result_flood_q;
        if (lookup_valid) begin
            result_hit_d   = lookup_hit;
            result_port_d  = lookup_hit ? lookup_port : '0;
            result_flood_d = !lookup_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q        <= '0;
            presc_q        <= '0;
            result_valid_q <= 1'b0;
            result_hit_q   <= 1'b0;
            result_port_q  <= '0;
            result_flood_q <= 1'b0;
            entry_count_q  <= '0;
            station_move_q <= 1'b0;
            for (int i = 0; i < TABLE_SIZE; i++) begin
                mac_q[i]  <= '0;
                port_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            valid_q        <= valid_d;
            presc_q        <= presc_d;
            result_valid_q <= result_valid_d;
            result_hit_q   <= result_hit_d;
            result_port_q  <= result_port_d;
            result_flood_q <= result_flood_d;
            entry_count_q  <= entry_count_d;
            station_move_q <= station_move_d;
            for (int i = 0; i < TABLE_SIZE; i++) begin
                mac_q[i]  <= mac_d[i];
                port_q[i] <= port_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end

    assign result_valid = result_valid_q;
    assign result_hit   = result_hit_q;
    assign result_port  = result_port_q;
    assign result_flood = result_flood_q;
    assign entry_count  = entry_count_q;
    assign station_move = station_move_q;

endmodule
